// File: rtl/decade_counter_if.sv
// Count-enable / clear / count / terminal-count bundle for decade_counter.
// DECADE_COUNTER_LOAD_EN adds the parallel-load pair (load, d).
interface decade_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in;
    logic             clr;
    logic [WIDTH-1:0] cnt;
    logic             tc;
`ifdef DECADE_COUNTER_LOAD_EN
    logic             load;
    logic [WIDTH-1:0] d;

    modport master (output in, clr, load, d, input cnt, tc);
    modport slave  (input in, clr, load, d, output cnt, tc);
`else
    modport master (output in, clr, input cnt, tc);
    modport slave  (input in, clr, output cnt, tc);
`endif
endinterface

// File: rtl/decade_counter.sv
// Modulo-(MAX_COUNT+1) up-counter with cascadable terminal count; BCD digit by default.
// Define DECADE_COUNTER_LOAD_EN to add a synchronous parallel load (load, d).
module decade_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 9
) (
    input logic            clk,
    input logic            rst_n,
    decade_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);

    if (MAX_COUNT >= (64'd1 << WIDTH)) begin : gen_bad_params
        $error("decade_counter: MAX_COUNT does not fit in WIDTH bits");
    end

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             at_max;

    assign at_max = (cnt_q == MaxVal);

    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr) begin
            cnt_d = '0;
`ifdef DECADE_COUNTER_LOAD_EN
        end else if (bus.load) begin
            // Out-of-range load data collapses to zero rather than entering an illegal state.
            cnt_d = (bus.d <= MaxVal) ? bus.d : '0;
`endif
        end else if (bus.in) begin
            // >= also recovers from a fault-induced value above MAX_COUNT.
            cnt_d = (cnt_q >= MaxVal) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.cnt = cnt_q;
    assign bus.tc  = at_max & bus.in;

    a_cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= MaxVal);

endmodule

// File: tb/tb_decade_counter.sv
// Bench for decade_counter: vector table, hand-written corner sequences, cascade,
// and randomized stimulus against a modulo-arithmetic reference model.
module tb_decade_counter;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned MAX_COUNT = 9;

    logic clk;
    logic rst_n;

    decade_counter_if #(.WIDTH(WIDTH)) bus_u ();
    decade_counter_if #(.WIDTH(WIDTH)) bus_t ();

    decade_counter #(.WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT)) u_units (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_u.slave)
    );

    decade_counter #(.WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT)) u_tens (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_t.slave)
    );

    // Tens digit advances on the units terminal count; clears together.
    assign bus_t.in  = bus_u.tc;
    assign bus_t.clr = bus_u.clr;
`ifdef DECADE_COUNTER_LOAD_EN
    assign bus_t.load = 1'b0;
    assign bus_t.d    = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic in;
        logic clr;
        int   exp_tc;   // before the edge
        int   exp_cnt;  // after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic in, input logic clr, input int tc, input int cnt);
        vec_t v;
        v.in = in; v.clr = clr; v.exp_tc = tc; v.exp_cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic set_load(input logic load, input int d);
`ifdef DECADE_COUNTER_LOAD_EN
        bus_u.load = load;
        bus_u.d    = WIDTH'(d);
`else
        if (load || d != 0) $display("note: load ignored in this build");
`endif
    endtask

    // Drive at the falling edge, check tc before the rising edge and cnt after it.
    task automatic step(input string name, input logic in, input logic clr, input int exp_tc,
                        input int exp_cnt);
        @(negedge clk);
        bus_u.in  = in;
        bus_u.clr = clr;
        #1;
        check({name, ".tc"}, int'(bus_u.tc), exp_tc);
        @(posedge clk);
        #1;
        check({name, ".cnt"}, int'(bus_u.cnt), exp_cnt);
    endtask

    int m_cnt;

    initial begin
        rst_n     = 1'b0;
        bus_u.in  = 1'b0;
        bus_u.clr = 1'b0;
        set_load(1'b0, 0);

        // Table: 12 enabled edges from reset, climb to 7, hold, wrap to 4, clear.
        for (int i = 1; i <= 12; i++) add_vec(1'b1, 1'b0, (i == 10) ? 1 : 0, i % 10);
        for (int i = 3; i <= 7; i++)  add_vec(1'b1, 1'b0, 0, i);
        for (int i = 0; i < 5; i++)   add_vec(1'b0, 1'b0, 0, 7);
        add_vec(1'b1, 1'b0, 0, 8);
        add_vec(1'b1, 1'b0, 0, 9);
        add_vec(1'b1, 1'b0, 1, 0);
        add_vec(1'b1, 1'b0, 0, 1);
        add_vec(1'b1, 1'b0, 0, 2);
        add_vec(1'b1, 1'b0, 0, 3);
        add_vec(1'b1, 1'b0, 0, 4);
        add_vec(1'b1, 1'b1, 0, 0);
        add_vec(1'b0, 1'b1, 0, 0);

        // Reset state
        #12;
        check("reset.cnt", int'(bus_u.cnt), 0);
        check("reset.tc", int'(bus_u.tc), 0);
        @(posedge clk);
        #1;
        check("reset_held.cnt", int'(bus_u.cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].in, vecs[i].clr, vecs[i].exp_tc,
                 vecs[i].exp_cnt);
        end

        // Clear at terminal count with enable: tc asserted, cnt still cleared.
        for (int i = 1; i <= 9; i++) step("to9", 1'b1, 1'b0, 0, i);
        step("clr_at_max", 1'b1, 1'b1, 1, 0);

        // Asynchronous reset mid-count at cnt=5, away from any clock edge.
        for (int i = 1; i <= 5; i++) step("to5", 1'b1, 1'b0, 0, i);
        @(negedge clk);
        bus_u.in = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.cnt", int'(bus_u.cnt), 0);
        check("async_rst.tc", int'(bus_u.tc), 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold.cnt", int'(bus_u.cnt), 0);
        @(negedge clk);
        bus_u.in = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_idle.cnt", int'(bus_u.cnt), 0);
        step("rst_release_count", 1'b1, 1'b0, 0, 1);

        // Cascade: 25 enabled edges -> tens 2, units 5.
        step("cascade_clr", 1'b0, 1'b1, 0, 0);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            bus_u.in  = 1'b1;
            bus_u.clr = 1'b0;
        end
        @(negedge clk);
        bus_u.in = 1'b0;
        check("cascade.units", int'(bus_u.cnt), 5);
        check("cascade.tens", int'(bus_t.cnt), 2);

`ifdef DECADE_COUNTER_LOAD_EN
        set_load(1'b1, 6);
        step("load6", 1'b0, 1'b0, 0, 6);
        set_load(1'b1, 12);
        step("load12", 1'b0, 1'b0, 0, 0);
        set_load(1'b1, 3);
        step("load3_in", 1'b1, 1'b0, 0, 3);
        set_load(1'b1, 9);
        step("clr_over_load", 1'b0, 1'b1, 0, 0);
        set_load(1'b0, 0);
`endif

        // Randomized stimulus against modulo-arithmetic reference.
        step("rand_clr", 1'b0, 1'b1, 0, 0);
        m_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            logic r_in, r_clr, r_load;
            int   r_d;
            int   exp_tc;
            r_in   = ($urandom_range(99) < 70);
            r_clr  = ($urandom_range(99) < 8);
            r_load = ($urandom_range(99) < 10);
            r_d    = int'($urandom_range(15));
`ifndef DECADE_COUNTER_LOAD_EN
            r_load = 1'b0;
            r_d    = 0;
`endif
            @(negedge clk);
            if ($urandom_range(99) < 3) begin
                rst_n = 1'b0;
                #1;
                m_cnt = 0;
                check("rand_async_rst.cnt", int'(bus_u.cnt), 0);
                rst_n = 1'b1;
            end
            bus_u.in  = r_in;
            bus_u.clr = r_clr;
            set_load(r_load, r_d);
            #1;
            exp_tc = (m_cnt == int'(MAX_COUNT) && r_in) ? 1 : 0;
            check("rand.tc", int'(bus_u.tc), exp_tc);
            if (r_clr)       m_cnt = 0;
            else if (r_load) m_cnt = (r_d <= int'(MAX_COUNT)) ? r_d : 0;
            else if (r_in)   m_cnt = (m_cnt + 1) % (int'(MAX_COUNT) + 1);
            @(posedge clk);
            #1;
            check("rand.cnt", int'(bus_u.cnt), m_cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
